// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th integrator sample and runs it through N_STAGES comb stages.
// Optional macro CIC_COMB_PRIME_EN suppresses the first N_STAGES*M startup outputs.
module cic_comb_decimator #(
    parameter int WIDTH    = 8,
    parameter int N_STAGES = 1,
    parameter int R        = 4,
    parameter int M        = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    logic [CW-1:0]    phase;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_data;

    // Comb stage i holds the output of stage i+1; x/v are its inputs.
    logic [WIDTH-1:0] st_d [N_STAGES];
    logic             st_v [N_STAGES];
    logic [WIDTH-1:0] dl   [N_STAGES][M];
    logic [WIDTH-1:0] x    [N_STAGES];
    logic             v    [N_STAGES];

    // Phase counter advances only on valid input samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= (phase == LAST) ? '0 : phase + CW'(1);
        end
    end

    // Capture the decimating sample into the stage-0 register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_valid <= 1'b0;
            dec_data  <= '0;
        end else begin
            dec_valid <= in_valid && (phase == LAST);
            if (in_valid && (phase == LAST)) begin
                dec_data <= in_data;
            end
        end
    end

    // Route each comb stage's input from the stage before it.
    always_comb begin
        x[0] = dec_data;
        v[0] = dec_valid;
        for (int i = 1; i < N_STAGES; i++) begin
            x[i] = st_d[i-1];
            v[i] = st_v[i-1];
        end
    end

    // Comb cascade: y = x - x delayed M samples, delay lines shift on valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_STAGES; i++) begin
                st_d[i] <= '0;
                st_v[i] <= 1'b0;
                for (int j = 0; j < M; j++) begin
                    dl[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N_STAGES; i++) begin
                st_v[i] <= v[i];
                if (v[i]) begin
                    st_d[i]  <= x[i] - dl[i][M-1];
                    dl[i][0] <= x[i];
                    for (int j = 1; j < M; j++) begin
                        dl[i][j] <= dl[i][j-1];
                    end
                end
            end
        end
    end

    assign out_data = st_d[N_STAGES-1];

`ifdef CIC_COMB_PRIME_EN
    localparam int PRIME = N_STAGES * M;
    localparam int PW    = $clog2(PRIME + 1);

    logic [PW-1:0] prime_cnt;

    // Count final-stage results until the delay lines hold real history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prime_cnt <= '0;
        end else if (st_v[N_STAGES-1] && (prime_cnt != PW'(PRIME))) begin
            prime_cnt <= prime_cnt + PW'(1);
        end
    end

    assign out_valid = st_v[N_STAGES-1] && (prime_cnt == PW'(PRIME));
`else
    assign out_valid = st_v[N_STAGES-1];
`endif

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Scoreboard bench for cic_comb_decimator using three parameterisations.
// Expected samples are queued by the drivers and checked by per-DUT monitors.
module tb_cic_comb_decimator;

`ifdef CIC_COMB_PRIME_EN
    localparam bit PRIME_ON = 1'b1;
`else
    localparam bit PRIME_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic       v1 = 0, v2 = 0, v3 = 0;
    logic [7:0] d1 = 0, d2 = 0, d3 = 0;
    logic       ov1, ov2, ov3;
    logic [7:0] od1, od2, od3;

    exp_t q1[$], q2[$], q3[$];
    int   pulses1 = 0, pulses2 = 0, pulses3 = 0;

    logic [1:0] ph1;
    logic [7:0] prev1;
    logic [7:0] p2a, p2b;
    logic [7:0] h3x[2], h3s[2];
    int         n3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cic_comb_decimator #(.WIDTH(8), .N_STAGES(1), .R(4), .M(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(v1), .in_data(d1),
        .out_valid(ov1), .out_data(od1));

    cic_comb_decimator #(.WIDTH(8), .N_STAGES(2), .R(1), .M(1)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_data(d2),
        .out_valid(ov2), .out_data(od2));

    cic_comb_decimator #(.WIDTH(8), .N_STAGES(2), .R(1), .M(2)) dut3 (
        .clk(clk), .rstn(rstn), .in_valid(v3), .in_data(d3),
        .out_valid(ov3), .out_data(od3));

    // Monitors: every out_valid pulse must match the next queued sample.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rstn && ov1 === 1'b1) begin
            pulses1++;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL dut1_extra got=%0d at cyc=%0d, required no pulse", od1, cyc);
            end else begin
                e = q1.pop_front();
                if (od1 !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL dut1_out got=%0d@%0d required=%0d@%0d", od1, cyc, e.data, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rstn && ov2 === 1'b1) begin
            pulses2++;
            tests++;
            if (q2.size() == 0) begin
                fails++;
                $display("FAIL dut2_extra got=%0d at cyc=%0d, required no pulse", od2, cyc);
            end else begin
                e = q2.pop_front();
                if (od2 !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL dut2_out got=%0d@%0d required=%0d@%0d", od2, cyc, e.data, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (rstn && ov3 === 1'b1) begin
            pulses3++;
            tests++;
            if (q3.size() == 0) begin
                fails++;
                $display("FAIL dut3_extra got=%0d at cyc=%0d, required no pulse", od3, cyc);
            end else begin
                e = q3.pop_front();
                if (od3 !== e.data || cyc != e.due) begin
                    fails++;
                    $display("FAIL dut3_out got=%0d@%0d required=%0d@%0d", od3, cyc, e.data, e.due);
                end
            end
        end
    end

    task automatic clear_models();
        q1.delete(); q2.delete(); q3.delete();
        ph1 = 0; prev1 = 0;
        p2a = 0; p2b = 0;
        h3x[0] = 0; h3x[1] = 0; h3s[0] = 0; h3s[1] = 0;
        n3 = 0;
        pulses1 = 0; pulses2 = 0; pulses3 = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 0;
        v1 = 0; v2 = 0; v3 = 0;
        clear_models();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    // Drivers: one input per cycle, expected result queued with its due cycle.
    task automatic drive1(input logic v, input logic [7:0] d);
        logic [7:0] y;
        @(posedge clk); #1;
        v1 = v; d1 = d;
        if (v) begin
            if (ph1 == 2'd3) begin
                y = d - prev1;
                prev1 = d;
                q1.push_back('{data: y, due: cyc + 2});
                ph1 = 0;
            end else begin
                ph1++;
            end
        end
    endtask

    task automatic drive2(input logic v, input logic [7:0] d);
        logic [7:0] s1, s2;
        @(posedge clk); #1;
        v2 = v; d2 = d;
        if (v) begin
            s1 = d - p2a;
            s2 = s1 - p2b;
            p2a = d;
            p2b = s1;
            q2.push_back('{data: s2, due: cyc + 3});
        end
    endtask

    task automatic drive3(input logic v, input logic [7:0] d);
        logic [7:0] s1, s2;
        @(posedge clk); #1;
        v3 = v; d3 = d;
        if (v) begin
            s1 = d - h3x[1];
            s2 = s1 - h3s[1];
            h3x[1] = h3x[0]; h3x[0] = d;
            h3s[1] = h3s[0]; h3s[0] = s1;
            n3++;
            if (!PRIME_ON || n3 > 4) q3.push_back('{data: s2, due: cyc + 3});
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        #1;
        tests += 3;
        if (ov1 !== 1'b0 || od1 !== 8'd0) begin
            fails++; $display("FAIL reset_dut1 got=%b/%0d required=0/0", ov1, od1);
        end
        if (ov2 !== 1'b0 || od2 !== 8'd0) begin
            fails++; $display("FAIL reset_dut2 got=%b/%0d required=0/0", ov2, od2);
        end
        if (ov3 !== 1'b0 || od3 !== 8'd0) begin
            fails++; $display("FAIL reset_dut3 got=%b/%0d required=0/0", ov3, od3);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 16; i++) drive1(1, 8'(i));
        repeat (4) drive1(0, 0);
        tests++;
        if (pulses1 != 4 || q1.size() != 0) begin
            fails++; $display("FAIL basic_count got=%0d left=%0d required=4/0", pulses1, q1.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) drive1(1, 8'(245 + i));
        repeat (4) drive1(0, 0);
        tests++;
        if (pulses1 != 4 || q1.size() != 0) begin
            fails++; $display("FAIL wrap_count got=%0d left=%0d required=4/0", pulses1, q1.size());
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int i = 0; i < 16; i++) drive1((i % 2) == 0, 8'(i + 1));
        repeat (4) drive1(0, 0);
        tests++;
        if (pulses1 != 2 || q1.size() != 0) begin
            fails++; $display("FAIL gapped_count got=%0d left=%0d required=2/0", pulses1, q1.size());
        end
    endtask

    task automatic test_second_order();
        logic [7:0] seq[5];
        seq[0] = 1; seq[1] = 3; seq[2] = 6; seq[3] = 10; seq[4] = 15;
        do_reset();
        for (int i = 0; i < 5; i++) drive2(1, seq[i]);
        repeat (5) drive2(0, 0);
        tests++;
        if (pulses2 != 5 || q2.size() != 0) begin
            fails++; $display("FAIL second_count got=%0d left=%0d required=5/0", pulses2, q2.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) drive1(1, 8'(i));
        drive1(0, 0);
        @(posedge clk); #1;
        tests++;
        if (ov1 !== 1'b1) begin
            fails++; $display("FAIL mid_pre_valid got=%b required=1", ov1);
        end
        #2 rstn = 0;
        q1.delete();
        #1;
        tests++;
        if (ov1 !== 1'b0 || od1 !== 8'd0) begin
            fails++; $display("FAIL mid_async got=%b/%0d required=0/0", ov1, od1);
        end
        @(posedge clk); #1;
        rstn = 1;
        clear_models();
        for (int i = 101; i <= 108; i++) drive1(1, 8'(i));
        repeat (4) drive1(0, 0);
        tests++;
        if (pulses1 != 2 || q1.size() != 0) begin
            fails++; $display("FAIL mid_after got=%0d left=%0d required=2/0", pulses1, q1.size());
        end
    endtask

    task automatic test_prime();
        logic [7:0] seq[5];
        int need;
        seq[0] = 3; seq[1] = 7; seq[2] = 20; seq[3] = 1; seq[4] = 9;
        need = PRIME_ON ? 1 : 5;
        do_reset();
        for (int i = 0; i < 5; i++) drive3(1, seq[i]);
        repeat (6) drive3(0, 0);
        tests++;
        if (pulses3 != need || q3.size() != 0) begin
            fails++; $display("FAIL prime_count got=%0d left=%0d required=%0d/0", pulses3, q3.size(), need);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_models();
        test_reset();
        test_basic();
        test_wrap();
        test_gapped();
        test_second_order();
        test_reset_mid();
        test_prime();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cic_comb_decimator.md
# cic_comb_decimator

Output half of the CIC decimation filter, placed directly downstream of the integrator cascade. It takes the integrator stream, keeps every R-th valid sample, and runs the kept samples through N_STAGES pipelined comb (differentiator) stages of differential delay M. All arithmetic is modular two's-complement, which cancels the wrap-around produced by the integrators. The result is the decimated filter output.

## Interface
- WIDTH, 8: data width of input, internal comb registers and output; must equal integrator width.
- N_STAGES, 1: number of comb stages (1..8); must equal number of integrator stages.
- R, 4: decimation ratio (1..256).
- M, 1: differential delay in decimated samples (1 or 2).
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a new integrator sample this cycle.
- in_data  input  WIDTH  integrator output sample.
- out_valid  output  1  one-cycle pulse, out_data holds a new decimated sample.
- out_data  output  WIDTH  comb cascade output.

## Operation
- Reset (async, rstn low): phase counter = 0, all comb delay lines = 0, all pipeline valids = 0, out_valid = 0, out_data = 0. Outputs take these values immediately, without a clock edge.
- Phase counter, $clog2(R) bits (1 bit min), counts only cycles with in_valid = 1: 0..R-1, then back to 0. Cycles with in_valid = 0 do not change it.
- Decimation: when in_valid = 1 and counter = R-1, in_data is captured into stage-0 register with dec_valid = 1. R = 1 captures every valid sample.
- Comb stage k (1..N_STAGES), updated only when stage k-1 valid = 1:
  - y_k = x_{k-1} - x_{k-1} delayed M decimated samples.
  - Delay line is M registers deep and shifts only on valid.
  - Stage valid is registered alongside the data.
- Arithmetic: WIDTH-bit subtraction, result truncated mod 2^WIDTH, no saturation, no overflow flag.
- out_data = stage N_STAGES register; out_valid = stage N_STAGES valid.
- No backpressure: the output must be consumed on the cycle out_valid = 1. The pipeline accepts one decimated sample per cycle with no bubbles.

## Timing
- Latency: the sample accepted with in_valid in cycle c (on the decimating phase) produces out_valid = 1 in cycle c + N_STAGES + 1.
- out_valid is high for exactly one cycle per decimated sample. Its spacing equals the spacing of the decimating input samples.
- With R = 1 and continuous in_valid, out_valid stays high continuously after the fill latency.
- Startup transient: the first N_STAGES*M outputs after reset are computed against zeroed delay lines. They are output as-is unless the Configuration macro is defined.
- Reset mid-operation: in-flight samples are discarded with no partial output. The first in_valid after rstn rises is phase 0.
- rstn deasserts synchronously to clk externally. The block needs no internal synchronizer.

## Configuration
- CIC_COMB_PRIME_EN defined:
  - A saturating counter (reset 0) counts stage-N_STAGES valids up to N_STAGES*M.
  - out_valid is forced to 0 until the count reaches N_STAGES*M, so the transient outputs are suppressed.
  - out_data still updates during this period.
- Not defined: there is no prime counter, and every stage-N_STAGES valid drives out_valid.

## Test plan
- Basic decimation, WIDTH=8, N=1, R=4, M=1:
  - Stimulus: in_data = 1,2,3,... with in_valid every cycle.
  - Response: out_data = 4,4,4,..., one out_valid every 4 cycles, first pulse 2 cycles after the 4th input.
- Wrap-around, same configuration:
  - Stimulus: integrator stream wrapping 252→0, so decimated samples are 248, 252, 0, 4.
  - Response: out_data = 4 at each step, including 0-252 = 4 mod 256.
- Second order, N=2, R=1, M=1:
  - Stimulus: in_data = 1,3,6,10,15.
  - Response: out_data = 1,1,1,1,1, with out_valid starting 3 cycles after the first input.
- Gapped input, R=4:
  - Stimulus: in_valid toggling 1,0,1,0,... for 16 cycles.
  - Response: exactly 2 out_valid pulses, with the phase counter frozen on idle cycles.
- Reset mid-stream:
  - Stimulus: assert rstn low while stage 1 valid = 1.
  - Response: out_valid and out_data are 0 immediately, no pulse follows, and the next 4th valid input after release is the first decimated sample.
- With CIC_COMB_PRIME_EN, N=2, M=2:
  - Response: the first 4 results are suppressed and the 5th raises out_valid.
  - Without the macro, the same run produces 5 pulses.
